// File: rtl/stream_mux_rr.sv
// Stream multiplexer: selects one of NCH valid/ready input channels, either by a fixed
// select or by round-robin arbitration, into a single registered output stage.
module stream_mux_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clock,
    input  logic                 reset_b,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    logic            load_en;
    logic            fixed_found;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            grant_found;
    logic [SELW-1:0] grant_idx;
    logic            transfer;
    logic [WIDTH-1:0] grant_data;
    logic [SELW-1:0] last_grant;

    assign load_en = !out_valid || out_ready;

    // An out-of-range sel simply matches no channel, so it yields no grant.
    always_comb begin
        fixed_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                fixed_found = 1'b1;
            end
        end
    end

    // Search upward from last_grant+1, wrapping; the first hit wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!rr_found && in_valid[(int'(last_grant) + k) % NCH]) begin
                rr_found = 1'b1;
                rr_idx   = SELW'((int'(last_grant) + k) % NCH);
            end
        end
    end

    always_comb begin
        if (mode) begin
            grant_found = rr_found;
            grant_idx   = rr_idx;
        end else begin
            grant_found = fixed_found;
            grant_idx   = sel;
        end
    end

    assign transfer = load_en && grant_found;

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
                if (transfer) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            if (grant_found) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Reset to NCH-1 so the first round-robin search begins at channel 0.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            last_grant <= SELW'(NCH - 1);
        end else if (transfer) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (WIDTH=4, NCH=4): fixed select, round-robin order,
// wrap-around, stall hold, drain to idle and asynchronous reset mid-stall.
module tb_stream_mux_rr;

    logic        clock = 1'b0;
    logic        reset_b;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_chan;

    int total  = 0;
    int passed = 0;

    stream_mux_rr #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".chan"},  32'(out_chan),  32'(c));
    endtask

    initial begin
        reset_b   = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 16'h0000;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #2;
        chk_out("reset", 1'b0, 4'h0, 2'd0);
        #5 reset_b = 1'b1;
        step();

        // Fixed select of channel 2
        mode = 1'b0; sel = 2'd2; in_data = 16'h0A00; in_valid = 4'b0100; out_ready = 1'b1;
        #1 chk("fix.ready", 32'(in_ready), 32'h4);
        step();
        chk_out("fix.out", 1'b1, 4'hA, 2'd2);

        // sel points to an idle channel: pending word drains, output goes idle and holds
        sel = 2'd3; in_valid = 4'b0111;
        #1 chk("nogrant.ready", 32'(in_ready), 32'h0);
        step();
        chk_out("nogrant.out", 1'b0, 4'hA, 2'd2);

        // Reset again so round-robin starts from a known last_grant
        #1 reset_b = 1'b0;
        #1 chk("rst2.valid", 32'(out_valid), 32'h0);
        #1 reset_b = 1'b1;
        step();

        mode = 1'b1; in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
        #1 chk("rr0.ready", 32'(in_ready), 32'h1);
        step(); chk_out("rr0", 1'b1, 4'h1, 2'd0);
        chk("rr1.ready", 32'(in_ready), 32'h2);
        step(); chk_out("rr1", 1'b1, 4'h2, 2'd1);
        chk("rr2.ready", 32'(in_ready), 32'h4);
        step(); chk_out("rr2", 1'b1, 4'h3, 2'd2);
        chk("rr3.ready", 32'(in_ready), 32'h8);
        step(); chk_out("rr3", 1'b1, 4'h4, 2'd3);
        chk("rr4.ready", 32'(in_ready), 32'h1);
        step(); chk_out("rr4", 1'b1, 4'h1, 2'd0);

        // Bring last_grant to 1, then alternate between channels 3 and 1
        in_valid = 4'b0010;
        step(); chk_out("wrap.pre", 1'b1, 4'h2, 2'd1);
        in_valid = 4'b1010;
        #1 chk("wrap.ready", 32'(in_ready), 32'h8);
        step(); chk_out("wrap.a", 1'b1, 4'h4, 2'd3);
        step(); chk_out("wrap.b", 1'b1, 4'h2, 2'd1);
        step(); chk_out("wrap.c", 1'b1, 4'h4, 2'd3);

        // Stall with changing inputs
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data  = 16'h1111 * 16'(i + 5);
            in_valid = 4'(i + 3);
            #1 chk("stall.ready", 32'(in_ready), 32'h0);
            step();
            chk_out("stall.hold", 1'b1, 4'h4, 2'd3);
        end
        out_ready = 1'b1; in_data = 16'h8765; in_valid = 4'b1111;
        #1 chk("unstall.ready", 32'(in_ready), 32'h1);
        step(); chk_out("unstall", 1'b1, 4'h5, 2'd0);

        // Mode change: fixed transfer updates last_grant, round-robin resumes after it
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        step(); chk_out("mode.fix", 1'b1, 4'h7, 2'd2);
        mode = 1'b1; in_valid = 4'b1111;
        #1 chk("mode.rr.ready", 32'(in_ready), 32'h8);
        step(); chk_out("mode.rr", 1'b1, 4'h8, 2'd3);

        // Async reset in the middle of a stall discards the held word
        out_ready = 1'b0;
        #1 chk("prerst.ready", 32'(in_ready), 32'h0);
        #1 reset_b = 1'b0;
        #1 chk_out("midrst", 1'b0, 4'h0, 2'd0);
        #1 reset_b = 1'b1; out_ready = 1'b1; in_data = 16'h4321;
        #1 chk("postrst.ready", 32'(in_ready), 32'h1);
        step(); chk_out("postrst", 1'b1, 4'h1, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
